// File: rtl/sha2_pkg.sv
// Shared SHA-2 schedule definitions: FSM states, sigma rotate/shift constants
// per word width, and the legal WORD_W/ROUNDS pairing.
package sha2_pkg;

  typedef enum logic {
    ST_LOAD   = 1'b0,
    ST_EXPAND = 1'b1
  } sched_state_t;

  localparam int WIN_DEPTH = 16;
  localparam int IDX_W     = 7;

  typedef struct packed {
    logic [6:0] rot_a;
    logic [6:0] rot_b;
    logic [6:0] shr_c;
  } sigma_cfg_t;

  // sel=0 gives small sigma0, sel=1 gives small sigma1.
  function automatic sigma_cfg_t sigma_cfg(input int word_w, input bit sel);
    sigma_cfg_t c;
    if (word_w == 64) begin
      if (sel) begin
        c.rot_a = 7'd19; c.rot_b = 7'd61; c.shr_c = 7'd6;
      end else begin
        c.rot_a = 7'd1;  c.rot_b = 7'd8;  c.shr_c = 7'd7;
      end
    end else begin
      if (sel) begin
        c.rot_a = 7'd17; c.rot_b = 7'd19; c.shr_c = 7'd10;
      end else begin
        c.rot_a = 7'd7;  c.rot_b = 7'd18; c.shr_c = 7'd3;
      end
    end
    return c;
  endfunction

  function automatic bit rounds_legal(input int word_w, input int rounds);
    return ((word_w == 32) && (rounds == 64)) || ((word_w == 64) && (rounds == 80));
  endfunction

endpackage

// File: rtl/sha2_sigma.sv
// Small sigma0/sigma1 of the SHA-2 message schedule; purely combinational,
// zero latency, no flow control.
module sha2_sigma
  import sha2_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter bit SEL    = 1'b0
) (
  input  logic [WORD_W-1:0] x,
  output logic [WORD_W-1:0] y
);

  localparam sigma_cfg_t CFG = sigma_cfg(WORD_W, SEL);
  localparam int RA = int'(CFG.rot_a);
  localparam int RB = int'(CFG.rot_b);
  localparam int RC = int'(CFG.shr_c);

  logic [WORD_W-1:0] rot_a;
  logic [WORD_W-1:0] rot_b;
  logic [WORD_W-1:0] shr_c;

  assign rot_a = {x[RA-1:0], x[WORD_W-1:RA]};
  assign rot_b = {x[RB-1:0], x[WORD_W-1:RB]};
  assign shr_c = x >> RC;
  assign y     = rot_a ^ rot_b ^ shr_c;

endmodule

// File: rtl/sha2_msg_schedule.sv
// SHA-2 message schedule: 16 input words pass through, the rest are expanded; 1-cycle latency,
// single output register stalls on w_ready. Optional blk_cnt output under SHA2_SCHED_STATS_EN.
module sha2_msg_schedule
  import sha2_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [WORD_W-1:0] w_data,
  output logic [IDX_W-1:0]  w_idx,
  output logic              w_last
`ifdef SHA2_SCHED_STATS_EN
  ,
  output logic [31:0]       blk_cnt
`endif
);

  if (!rounds_legal(WORD_W, ROUNDS)) begin : g_bad_cfg
    $error("sha2_msg_schedule: illegal WORD_W/ROUNDS combination");
  end

  localparam logic [IDX_W-1:0] T_LOAD_END = IDX_W'(WIN_DEPTH - 1);
  localparam logic [IDX_W-1:0] T_END      = IDX_W'(ROUNDS - 1);

  sched_state_t      state;
  logic [IDX_W-1:0]  t;
  logic [WORD_W-1:0] win [WIN_DEPTH];

  logic              advance;
  logic              load_fire;
  logic              exp_fire;
  logic              step;
  logic [WORD_W-1:0] sig0;
  logic [WORD_W-1:0] sig1;
  logic [WORD_W-1:0] w_new;
  logic [WORD_W-1:0] w_next;

  assign advance   = !w_valid || w_ready;
  assign in_ready  = (state == ST_LOAD) && advance;
  assign load_fire = in_valid && in_ready;
  assign exp_fire  = (state == ST_EXPAND) && advance;
  assign step      = load_fire || exp_fire;

  // win[0] holds W[t-16], win[15] holds W[t-1].
  sha2_sigma #(.WORD_W(WORD_W), .SEL(1'b0)) u_sig0 (.x(win[1]),  .y(sig0));
  sha2_sigma #(.WORD_W(WORD_W), .SEL(1'b1)) u_sig1 (.x(win[14]), .y(sig1));

  assign w_new  = sig1 + win[9] + sig0 + win[0];
  assign w_next = load_fire ? in_data : w_new;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_LOAD;
      t       <= '0;
      w_valid <= 1'b0;
      w_data  <= '0;
      w_idx   <= '0;
      w_last  <= 1'b0;
      for (int i = 0; i < WIN_DEPTH; i++) begin
        win[i] <= '0;
      end
    end else if (abort) begin
      state   <= ST_LOAD;
      t       <= '0;
      w_valid <= 1'b0;
      for (int i = 0; i < WIN_DEPTH; i++) begin
        win[i] <= '0;
      end
    end else if (step) begin
      for (int i = 0; i < WIN_DEPTH - 1; i++) begin
        win[i] <= win[i+1];
      end
      win[WIN_DEPTH-1] <= w_next;
      w_data  <= w_next;
      w_idx   <= t;
      w_last  <= (t == T_END);
      w_valid <= 1'b1;
      if (t == T_END) begin
        // Back to LOAD so the next block's first word can land on the very next edge.
        t     <= '0;
        state <= ST_LOAD;
      end else begin
        t <= t + IDX_W'(1);
        if ((state == ST_LOAD) && (t == T_LOAD_END)) begin
          state <= ST_EXPAND;
        end
      end
    end else if (advance) begin
      // Only reachable in LOAD with no input word: the pending word was taken, go idle.
      w_valid <= 1'b0;
    end
  end

`ifdef SHA2_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt <= '0;
    end else if (w_valid && w_ready && w_last) begin
      blk_cnt <= blk_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sha2_msg_schedule.sv
// Bench for sha2_msg_schedule: SHA-256 and SHA-512 instances against a reference schedule model.
module tb_sha2_msg_schedule;

  logic        clk;
  logic        rst;
  logic        abort;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_data;
  logic [6:0]  w_idx;
  logic        w_last;

  logic        in_valid64;
  logic        in_ready64;
  logic [63:0] in_data64;
  logic        w_valid64;
  logic        w_ready64;
  logic [63:0] w_data64;
  logic [6:0]  w_idx64;
  logic        w_last64;

`ifdef SHA2_SCHED_STATS_EN
  logic [31:0] blk_cnt;
  logic [31:0] blk_cnt64;
  logic [31:0] blk_before;
`endif

  sha2_msg_schedule #(.WORD_W(32), .ROUNDS(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .abort    (abort),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .w_data   (w_data),
    .w_idx    (w_idx),
    .w_last   (w_last)
`ifdef SHA2_SCHED_STATS_EN
    ,
    .blk_cnt  (blk_cnt)
`endif
  );

  sha2_msg_schedule #(.WORD_W(64), .ROUNDS(80)) dut64 (
    .clk      (clk),
    .rst      (rst),
    .abort    (abort),
    .in_valid (in_valid64),
    .in_ready (in_ready64),
    .in_data  (in_data64),
    .w_valid  (w_valid64),
    .w_ready  (w_ready64),
    .w_data   (w_data64),
    .w_idx    (w_idx64),
    .w_last   (w_last64)
`ifdef SHA2_SCHED_STATS_EN
    ,
    .blk_cnt  (blk_cnt64)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [63:0] src_q[$];
  logic [71:0] exp_q[$];   // {last, idx[6:0], data[63:0]}
  logic [63:0] got_q[$];
  int          first_c;
  int          last_c;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model: W[t] recurrence straight from the SHA-2 definition
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
    logic [63:0] m;
    m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    return ((x >> n) | (x << (w - n))) & m;
  endfunction

  function automatic logic [63:0] sig(input logic [63:0] x, input int w, input bit one);
    if (w == 32) begin
      if (one) return rotr(x, 17, 32) ^ rotr(x, 19, 32) ^ (x >> 10);
      return rotr(x, 7, 32) ^ rotr(x, 18, 32) ^ (x >> 3);
    end
    if (one) return rotr(x, 19, 64) ^ rotr(x, 61, 64) ^ (x >> 6);
    return rotr(x, 1, 64) ^ rotr(x, 8, 64) ^ (x >> 7);
  endfunction

  task automatic add_block(input int w, input int rounds, input logic [63:0] m[16]);
    logic [63:0] sch[80];
    logic [63:0] msk;
    logic [6:0]  idx;
    logic        lst;
    msk = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    for (int t = 0; t < rounds; t++) begin
      if (t < 16) begin
        sch[t] = m[t] & msk;
        src_q.push_back(sch[t]);
      end else begin
        sch[t] = (sig(sch[t-2], w, 1'b1) + sch[t-7] + sig(sch[t-15], w, 1'b0) + sch[t-16]) & msk;
      end
      idx = 7'(t);
      lst = (t == rounds - 1);
      exp_q.push_back({lst, idx, sch[t]});
    end
  endtask

  task automatic rand_block(input int w, input int rounds);
    logic [63:0] m[16];
    for (int i = 0; i < 16; i++) m[i] = {$urandom, $urandom};
    add_block(w, rounds, m);
  endtask

  task automatic abc_block(input int w, input int rounds);
    logic [63:0] m[16];
    for (int i = 0; i < 16; i++) m[i] = '0;
    m[0]  = (w == 64) ? 64'h6162_6380_0000_0000 : 64'h0000_0000_6162_6380;
    m[15] = 64'h18;
    add_block(w, rounds, m);
  endtask

  // Feeds src_q into the 32-bit DUT and scores n_out output words; inputs change only on negedges.
  task automatic drive32(input int n_out, input int rdy_pct, input int vld_pct);
    int          cyc;
    int          n;
    logic        stalled;
    logic [39:0] held;
    cyc = 0; n = 0; stalled = 1'b0; held = '0;
    got_q.delete();
    first_c = -1; last_c = -1;
    while (n < n_out && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      if (stalled) check("stall_hold", {31'd0, w_valid, w_last, w_idx, w_data}, {31'd0, 1'b1, held});
      w_ready  = ($urandom_range(99) < rdy_pct);
      in_valid = (src_q.size() > 0) && ($urandom_range(99) < vld_pct);
      in_data  = in_valid ? src_q[0][31:0] : $urandom;
      #1;
      if (in_valid && in_ready) void'(src_q.pop_front());
      if (w_valid && w_ready) begin
        if (exp_q.size() == 0) check("w32_extra", 72'd1, 72'd0);
        else check("w32", {w_last, w_idx, 32'd0, w_data}, exp_q.pop_front());
        got_q.push_back({32'd0, w_data});
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        n++;
      end
      stalled = w_valid && !w_ready;
      held    = {w_last, w_idx, w_data};
    end
    check("drive32_count", 72'(n), 72'(n_out));
  endtask

  task automatic drive64(input int n_out);
    int cyc;
    int n;
    cyc = 0; n = 0;
    got_q.delete();
    while (n < n_out && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      w_ready64  = ($urandom_range(99) < 75);
      in_valid64 = (src_q.size() > 0) && ($urandom_range(99) < 80);
      in_data64  = in_valid64 ? src_q[0] : {$urandom, $urandom};
      #1;
      if (in_valid64 && in_ready64) void'(src_q.pop_front());
      if (w_valid64 && w_ready64) begin
        if (exp_q.size() == 0) check("w64_extra", 72'd1, 72'd0);
        else check("w64", {w_last64, w_idx64, w_data64}, exp_q.pop_front());
        got_q.push_back(w_data64);
        n++;
      end
    end
    check("drive64_count", 72'(n), 72'(n_out));
  endtask

  initial begin
    rst = 1'b1; abort = 1'b0;
    in_valid = 1'b0; in_data = '0; w_ready = 1'b0;
    in_valid64 = 1'b0; in_data64 = '0; w_ready64 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("rst_outputs", {w_valid, w_last, w_idx, w_data}, 72'd0);
    check("rst_in_ready", 72'(in_ready), 72'd1);
    check("rst64_outputs", {w_valid64, w_last64, w_idx64, w_data64}, 72'd0);
`ifdef SHA2_SCHED_STATS_EN
    check("rst_blk_cnt", 72'(blk_cnt), 72'd0);
`endif

    // SHA-512 "abc" with random stalls
    abc_block(64, 80);
    drive64(80);
    check("abc64_w16", 72'(got_q[16]), 72'h6162_6380_0000_0000);
    check("abc64_w17", 72'(got_q[17]), 72'h0003_0000_0000_00C0);
    in_valid64 = 1'b0; w_ready64 = 1'b1;

    // SHA-256 "abc" at full rate
    abc_block(32, 64);
    drive32(64, 100, 100);
    check("abc32_w16", 72'(got_q[16]), 72'h6162_6380);
    check("abc32_w17", 72'(got_q[17]), 72'h000F_0000);

    // two back-to-back blocks, no bubble allowed
    @(negedge clk);
`ifdef SHA2_SCHED_STATS_EN
    blk_before = blk_cnt;
`endif
    rand_block(32, 64);
    rand_block(32, 64);
    drive32(128, 100, 100);
    check("no_bubble_span", 72'(last_c - first_c + 1), 72'd128);
    @(negedge clk);
`ifdef SHA2_SCHED_STATS_EN
    check("blk_cnt_b2b", 72'(blk_cnt - blk_before), 72'd2);
`endif

    // random backpressure and input gaps
    for (int b = 0; b < 3; b++) rand_block(32, 64);
    drive32(192, 60, 70);

    // abort while W30 is on the output
    rand_block(32, 64);
    drive32(30, 100, 100);
    @(negedge clk);
`ifdef SHA2_SCHED_STATS_EN
    blk_before = blk_cnt;
`endif
    check("abort_at_idx", {w_valid, w_idx}, {1'b1, 7'd30});
    abort = 1'b1; w_ready = 1'b0; in_valid = 1'b1; in_data = $urandom;
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    #1;
    check("abort_w_valid", 72'(w_valid), 72'd0);
    check("abort_in_ready", 72'(in_ready), 72'd1);
`ifdef SHA2_SCHED_STATS_EN
    check("abort_blk_cnt", 72'(blk_cnt), 72'(blk_before));
`endif
    exp_q.delete(); src_q.delete();
    rand_block(32, 64);
    drive32(64, 80, 80);

    // reset in the middle of a load
    rand_block(32, 64);
    drive32(5, 100, 100);
    @(negedge clk);
    check("rst_at_idx", {w_valid, w_idx}, {1'b1, 7'd5});
    rst = 1'b1; w_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_outputs", {w_valid, w_last, w_idx, w_data}, 72'd0);
    check("midrst_in_ready", 72'(in_ready), 72'd1);
`ifdef SHA2_SCHED_STATS_EN
    check("midrst_blk_cnt", 72'(blk_cnt), 72'd0);
`endif
    exp_q.delete(); src_q.delete();
    rand_block(32, 64);
    drive32(64, 70, 70);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
